// File: rtl/vedic_pkg.sv
// Shared widths, step schedule and FSM state type for the sequential 6x6 Vedic multiplier.
package vedic_pkg;

   localparam int HALF_W  = 3;
   localparam int FULL_W  = 6;
   localparam int PROD_W  = 12;
   localparam int N_STEPS = 4;

   localparam logic [2:0] SHIFT_0 = 3'd0;
   localparam logic [2:0] SHIFT_1 = 3'd3;
   localparam logic [2:0] SHIFT_2 = 3'd3;
   localparam logic [2:0] SHIFT_3 = 3'd6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Step k pairs a-half step[1] with b-half step[0]; weight is the sum of half offsets.
   function automatic logic [2:0] step_shift(input logic [1:0] step);
      case (step)
         2'd0:    return SHIFT_0;
         2'd1:    return SHIFT_1;
         2'd2:    return SHIFT_2;
         default: return SHIFT_3;
      endcase
   endfunction

endpackage

// File: rtl/vedic_mult3x3.sv
// Combinational 3x3 Urdhva-Tiryagbhyam (vertical and crosswise) multiplier core.
module vedic_mult3x3
   import vedic_pkg::*;
(
   input  logic [HALF_W-1:0]   x,
   input  logic [HALF_W-1:0]   y,
   output logic [2*HALF_W-1:0] z
);

   logic       c0, c4;
   logic [1:0] c1, c2, c3;

   // Column sums of the crosswise bit products, weights 2^0 .. 2^4.
   assign c0 = x[0] & y[0];
   assign c1 = 2'(x[1] & y[0]) + 2'(x[0] & y[1]);
   assign c2 = 2'(x[2] & y[0]) + 2'(x[1] & y[1]) + 2'(x[0] & y[2]);
   assign c3 = 2'(x[2] & y[1]) + 2'(x[1] & y[2]);
   assign c4 = x[2] & y[2];

   assign z = 6'(c0)
            + (6'(c1) << 1)
            + (6'(c2) << 2)
            + (6'(c3) << 3)
            + (6'(c4) << 4);

endmodule

// File: rtl/vedic_mult6_seq.sv
// 6x6 unsigned multiplier: one 3x3 Vedic core time-shared over four steps, valid/ready on both sides.
module vedic_mult6_seq
   import vedic_pkg::*;
#(
   parameter bit ZERO_SKIP = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [FULL_W-1:0] a,
   input  logic [FULL_W-1:0] b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PROD_W-1:0] p,
   output logic              busy
);

   state_t              state_q, state_d;
   logic [1:0]          step_q;
   logic [FULL_W-1:0]   a_q, b_q;
   logic [PROD_W-1:0]   acc_q;

   logic [HALF_W-1:0]   a_sel, b_sel;
   logic [2*HALF_W-1:0] pp;
   logic [PROD_W-1:0]   pp_shifted;
   logic                zero_op;

   assign a_sel      = step_q[1] ? a_q[FULL_W-1:HALF_W] : a_q[HALF_W-1:0];
   assign b_sel      = step_q[0] ? b_q[FULL_W-1:HALF_W] : b_q[HALF_W-1:0];
   assign pp_shifted = PROD_W'(pp) << step_shift(step_q);
   assign zero_op    = ZERO_SKIP && ((a_q == '0) || (b_q == '0));

   vedic_mult3x3 u_core (
      .x (a_sel),
      .y (b_sel),
      .z (pp)
   );

   // NOTE: every variable gets its default before the case; a missing branch would infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (in_valid) state_d = MUL;
         MUL:  if (zero_op || (step_q == 2'(N_STEPS - 1))) state_d = DONE;
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: all sequential state uses non-blocking assignment so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         step_q  <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q    <= a;
                  b_q    <= b;
                  acc_q  <= '0;
                  step_q <= '0;
               end
            end
            MUL: begin
               // A zero operand leaves the cleared accumulator as the final product.
               if (!zero_op) begin
                  acc_q  <= acc_q + pp_shifted;
                  step_q <= step_q + 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = (state_q == DONE);
   assign p         = acc_q;

endmodule

// File: tb/tb_vedic_mult6_seq.sv
// Scoreboard bench for vedic_mult6_seq: directed vectors, full sweep, backpressure, reset and zero-skip.
module tb_vedic_mult6_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready, busy;
   logic [5:0]  a, b;
   logic [11:0] p;

   logic        in_valid_nz, in_ready_nz, out_valid_nz, out_ready_nz, busy_nz;
   logic [11:0] p_nz;

   logic [11:0] exp_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   vedic_mult6_seq #(.ZERO_SKIP(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .p(p), .busy(busy)
   );

   vedic_mult6_seq #(.ZERO_SKIP(1'b0)) dut_nz (
      .clk(clk), .rst(rst), .in_valid(in_valid_nz), .in_ready(in_ready_nz),
      .a(a), .b(b), .out_valid(out_valid_nz), .out_ready(out_ready_nz),
      .p(p_nz), .busy(busy_nz)
   );

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: a handshake seen at the negedge completes on the following posedge.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_unexpected: got p=%0d, expected no output", p);
         end else begin
            check("sb_p", int'(p), int'(exp_q.pop_front()));
         end
      end
   end

   // Returns just after the accepting edge.
   task automatic send(input logic [5:0] ta, input logic [5:0] tb, input logic [11:0] ep);
      int n;
      n = 0;
      while (!in_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) check("send_timeout", 0, 1);
      a        = ta;
      b        = tb;
      in_valid = 1'b1;
      exp_q.push_back(ep);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Samples 10 post-edge points starting at the accept edge.
   task automatic measure(output int lat, output int bc);
      lat = -1;
      bc  = 0;
      for (int j = 0; j < 10; j++) begin
         if (busy) bc++;
         if (out_valid && lat < 0) lat = j;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      int lat, bc, last, n;
      logic [5:0] va[3];
      logic [5:0] vb[3];

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
      in_valid_nz = 1'b0; out_ready_nz = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_p", p, 0);
      rst = 1'b0;

      // Full scale
      send(6'd63, 6'd63, 12'd3969);
      measure(lat, bc);
      check("full_latency", lat, 4);
      check("full_busy_cycles", bc, 5);

      // Mixed halves
      send(6'd5, 6'd6, 12'd30);
      send(6'h2A, 6'h15, 12'd882);

      // Zero skip enabled: one-cycle latency
      send(6'd0, 6'd45, 12'd0);
      measure(lat, bc);
      check("zskip_latency", lat, 1);
      check("zskip_busy_cycles", bc, 2);

      // Zero skip disabled instance: full four-step latency
      a = 6'd0; b = 6'd45; in_valid_nz = 1'b1;
      @(posedge clk); #1;
      in_valid_nz = 1'b0;
      lat = -1;
      for (int j = 0; j < 10; j++) begin
         if (out_valid_nz && lat < 0) begin
            lat = j;
            check("nz_p", int'(p_nz), 0);
         end
         @(posedge clk); #1;
      end
      check("nz_latency", lat, 4);

      // Backpressure
      out_ready = 1'b0;
      send(6'd7, 6'd9, 12'd63);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("bp_valid_rise", out_valid, 1);
      for (int j = 0; j < 10; j++) begin
         check("bp_hold_valid", out_valid, 1);
         check("bp_hold_p", int'(p), 63);
         check("bp_in_ready", in_ready, 0);
         a = 6'(j + 1); b = 6'(j + 20); in_valid = j[0];
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      send(6'd3, 6'd5, 12'd15);

      // Reset at step 2
      send(6'd63, 6'd63, 12'd3969);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      void'(exp_q.pop_back());
      check("mid_rst_in_ready", in_ready, 1);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_p", int'(p), 0);
      rst = 1'b0;
      send(6'd3, 6'd3, 12'd9);

      // Back-to-back with in_valid held high
      va[0] = 6'd12; vb[0] = 6'd11;
      va[1] = 6'd40; vb[1] = 6'd33;
      va[2] = 6'd9;  vb[2] = 6'd62;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      last = -1;
      a = va[0]; b = vb[0]; in_valid = 1'b1;
      exp_q.push_back(12'd132);
      for (int k = 0; k < 3; k++) begin
         n = 0;
         while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
         end
         @(posedge clk); #1;
         if (last >= 0) check("b2b_gap", cyc - last, 6);
         last = cyc;
         if (k == 0) begin a = va[1]; b = vb[1]; exp_q.push_back(12'd1320); end
         if (k == 1) begin a = va[2]; b = vb[2]; exp_q.push_back(12'd558); end
      end
      in_valid = 1'b0;

      // Exhaustive sweep
      for (int i = 0; i < 64; i++)
         for (int j = 0; j < 64; j++)
            send(i[5:0], j[5:0], 12'(i * j));

      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_queue", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
